serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor with carry/borrow in and out, and signed overflow and zero flags.
- Processes DIGIT bits per clock, least-significant digit first, through a ripple slice.
- Trades latency for area in datapaths that need wide add/sub without a full-width carry chain.
- Uses a start/busy/done handshake. Results are held until the next accepted start.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
DIGIT, 4, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.
(derived) N = WIDTH/DIGIT, number of RUN cycles.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin, cin is borrow-in).
a  input  WIDTH  operand A, latched on accepted start.
b  input  WIDTH  operand B, latched on accepted start.
cin  input  1  carry-in (add) / borrow-in (sub), latched on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result and flags are valid from this cycle.
result  output  WIDTH  sum/difference.
cout  output  1  carry-out (add) / borrow-out (sub; 1 when a < b+cin unsigned).
ovf  output  1  signed two's-complement overflow.
zero  output  1  result == 0.

Behaviour:
- Reset (synchronous, rst=1 at edge): state IDLE; busy, done, cout, ovf, zero = 0; result = 0; digit counter = 0.
  - Reset overrides everything, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE, start=1 at edge E0: latch a, b, cin, mode; counter=0; go to RUN.
  - RUN: each edge computes digit[counter] with the running carry/borrow and writes it into the shift/result register. Counter increments.
    - At the edge that processes digit N-1 (EN): register the final result, cout, ovf and zero; go to DONE.
  - DONE: done=1 for exactly one cycle.
    - Next edge: if start=1, accepted as in IDLE (back-to-back); else go to IDLE.
- Latency: done is high in the cycle after edge E_N, i.e. N+1 edges after the start edge (5 edges for the defaults).
- busy is high from after E0 until after EN, and is never high at the same time as done.
- start while busy is ignored. Input changes during RUN have no effect.
- Outputs hold their last values in IDLE until the next accepted start completes.
  - result/flags are not cleared at start; they update only at EN.
- Arithmetic:
  - Subtract is a + ~b + ~cin internally; borrow = ~carry at every digit boundary.
  - Add overflow: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - Subtract overflow: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - cout is always the raw unsigned carry/borrow and is unaffected by saturation.
- DIGIT==WIDTH (N=1): one RUN cycle; done occurs 2 edges after start.

Optional Feature:
SERIAL_ADDSUB_SAT_EN
- Defined: on ovf=1, result clamps to signed max (0x7FFF for WIDTH=16) if a[MSB]==0, or to signed min (0x8000) otherwise. ovf still reports 1, and zero is computed on the clamped value.
- Undefined: result wraps modulo 2^WIDTH; no clamp logic is present.

Decomposition:
- Package addsub_pkg:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - State encoding ST_IDLE/ST_RUN/ST_DONE.
  - A function computing N and the counter width clog2(N), with minimum 1.
- One sub-module, addsub_digit: combinational DIGIT-bit ripple add/sub slice.
  - Inputs: a_d, b_d, c_in, mode.
  - Outputs: s_d, c_out, plus the MSB-position carry needed for the overflow check.
  - Instantiated once and time-multiplexed by the counter.

Test Plan:
- WIDTH=16, DIGIT=4. Add 0x1234+0x0FFF, cin=0 -> result 0x2233, cout=0, ovf=0, zero=0; done exactly 5 edges after start, one cycle wide.
- Sub 0x0003-0x0005, cin=0 -> result 0xFFFE, cout(borrow)=1, ovf=0.
- Sub 0x8000-0x0001 -> 0x7FFF, borrow=0, ovf=1; with SERIAL_ADDSUB_SAT_EN -> 0x8000.
- Add 0x7FFF+0x0001 -> 0x8000, ovf=1; with SAT -> 0x7FFF.
- Pulse start again during RUN with different operands -> ignored, first result returned. Then assert start in the DONE cycle with 0xFFFF+0x0001 -> accepted; done 5 edges later with result 0x0000, cout=1, zero=1.
- Assert rst at the 2nd RUN edge -> next cycle busy=0, done=0, result=0, all flags 0. A fresh add 0x0001+0x0001 with cin=1 then gives 0x0003.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: mode encoding, FSM
// state encoding and helpers deriving the digit count and counter width.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to walk all digits.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit so N=1 still has a counter.
    function automatic int calc_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// One DIGIT-bit ripple slice. Subtraction is performed as a + ~b + carry,
// where the caller supplies the already-inverted borrow as carry-in.
// Also exposes the carry into the top bit so the caller can derive signed
// overflow on the most significant digit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    input  logic             mode,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb
);
    import addsub_pkg::*;

    logic [DIGIT-1:0] b_eff;
    logic             c;

    // Ripple through the digit, capturing the carry entering the top bit.
    always_comb begin
        b_eff = (mode == MODE_SUB) ? ~b_d : b_d;
        c     = c_in;
        c_msb = c_in;
        s_d   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = c;
            end
            s_d[i] = a_d[i] ^ b_eff[i] ^ c;
            c      = (a_d[i] & b_eff[i]) | (c & (a_d[i] ^ b_eff[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with start/busy/done handshake.
// Operands are latched on an accepted start and shifted right one digit per
// RUN cycle through a single addsub_digit slice; the sum digits shift into an
// accumulator from the top. Result and flags update only when the last digit
// completes and are held until the next operation finishes.
// Optional build macro: SERIAL_ADDSUB_SAT_EN clamps overflowing results to the
// signed limit; without it results wrap.
//
// state   | meaning
// ST_IDLE | waiting for start, outputs hold last result
// ST_RUN  | one digit processed per cycle, busy high
// ST_DONE | done pulse, start accepted back-to-back
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = calc_n(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] res_final;
    logic             ovf_final;

    assign dig_a = opa_q[DIGIT-1:0];
    assign dig_b = opb_q[DIGIT-1:0];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d   (dig_a),
        .b_d   (dig_b),
        .c_in  (carry_q),
        .mode  (mode_q),
        .s_d   (dig_s),
        .c_out (dig_cout),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the top so after N shifts digit 0 sits at the LSB.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // Final result and overflow, valid while the last digit is in the slice.
    always_comb begin
        ovf_final = dig_cout ^ dig_cmsb;
        res_final = acc_next;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_final) begin
            // dig_a's top bit is operand A's sign bit on the last digit.
            res_final = dig_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Next-state, operand shifting and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    mode_d  = mode;
                    // Borrow-in becomes an inverted carry-in for a + ~b.
                    carry_d = (mode == MODE_SUB) ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = res_final;
                    cout_d   = (mode_q == MODE_SUB) ? ~dig_cout : dig_cout;
                    ovf_d    = ovf_final;
                    zero_d   = (res_final == '0);
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= MODE_ADD;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=16, DIGIT=4). Expected results
// are queued at issue time; a negedge monitor pops one per done pulse.
module tb_serial_addsub;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout, ovf, zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t last_exp;
    logic prev_done = 1'b0;

    serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the full operands.
    function automatic exp_t model(input logic [W-1:0] a_i, b_i, input logic c_i, m_i);
        exp_t   e;
        longint lim, ua, ub, sa, sb, full, sres;
        lim  = longint'(1) << W;
        ua   = longint'(a_i);
        ub   = longint'(b_i);
        sa   = longint'($signed(a_i));
        sb   = longint'($signed(b_i));
        if (m_i == 1'b0) begin
            full   = ua + ub + longint'(c_i);
            e.cout = (full >= lim);
            sres   = sa + sb + longint'(c_i);
        end else begin
            full   = ua - ub - longint'(c_i);
            e.cout = (ua < ub + longint'(c_i));
            sres   = sa - sb - longint'(c_i);
        end
        if (full < 0) full = full + lim;
        full  = full % lim;
        e.res = W'(full);
        e.ovf = (sres > lim / 2 - 1) || (sres < -(lim / 2));
`ifdef SERIAL_ADDSUB_SAT_EN
        if (e.ovf) e.res = (sa < 0) ? W'(lim / 2) : W'(lim / 2 - 1);
`endif
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Monitor: compare on every done pulse, independent of the driver.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                exp_t e;
                n_tests++;
                if (busy) begin
                    n_fail++;
                    $display("FAIL busy_with_done: busy=%0b done=%0b, required busy=0", busy, done);
                end else if (prev_done) begin
                    n_fail++;
                    $display("FAIL done_width: done high two cycles in a row, required one-cycle pulse");
                end else if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done with empty scoreboard, result=%h", result);
                end else begin
                    e = sb_q.pop_front();
                    if (result !== e.res || cout !== e.cout || ovf !== e.ovf || zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL result_check: got res=%h cout=%b ovf=%b zero=%b, required res=%h cout=%b ovf=%b zero=%b",
                                 result, cout, ovf, zero, e.res, e.cout, e.ovf, e.zero);
                    end
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // Present operands with start high for one edge (the start edge E0).
    task automatic issue(input logic [W-1:0] a_i, b_i, input logic c_i, m_i, input exp_t e);
        a     = a_i;
        b     = b_i;
        cin   = c_i;
        mode  = m_i;
        start = 1'b1;
        sb_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done; it must appear N posedges after the start edge
    // (start edge plus N RUN edges = N+1 edges).
    task automatic wait_done(input int already);
        int k;
        k = already;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d edges", k);
        end else if (k != N) begin
            n_fail++;
            $display("FAIL latency: done after %0d edges past start, required %0d", k, N);
        end
    endtask

    task automatic check_idle_hold();
        n_tests++;
        if (busy || done || result !== last_exp.res || cout !== last_exp.cout ||
            ovf !== last_exp.ovf || zero !== last_exp.zero) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b done=%b res=%h, required busy=0 done=0 res=%h",
                     busy, done, result, last_exp.res);
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 ||
            ovf !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b res=%h cout=%b ovf=%b zero=%b, required all 0",
                     name, busy, done, result, cout, ovf, zero);
        end
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic         rc, rm;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("reset_state");

        // Add with no overflow.
        issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, '{res: 16'h2233, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        wait_done(0);
        @(posedge clk); #1;
        check_idle_hold();

        // Subtract producing a borrow.
        issue(16'h0003, 16'h0005, 1'b0, 1'b1, '{res: 16'hFFFE, cout: 1'b1, ovf: 1'b0, zero: 1'b0});
        wait_done(0);
        @(posedge clk); #1;

        // Subtract with signed overflow.
`ifdef SERIAL_ADDSUB_SAT_EN
        e = '{res: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
`else
        e = '{res: 16'h7FFF, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
`endif
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, e);
        wait_done(0);
        @(posedge clk); #1;

        // Add with signed overflow.
`ifdef SERIAL_ADDSUB_SAT_EN
        e = '{res: 16'h7FFF, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
`else
        e = '{res: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
`endif
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, e);
        wait_done(0);
        @(posedge clk); #1;

        // Start pulse during RUN must be ignored.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, '{res: 16'h3333, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0F0F; cin = 1'b1; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2);
        // Back-to-back start in the DONE cycle.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{res: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        wait_done(0);
        @(posedge clk); #1;

        // Reset at the second RUN edge discards the operation.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("mid_run_reset");
        issue(16'h0001, 16'h0001, 1'b1, 1'b0, '{res: 16'h0003, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        wait_done(0);

        // Randomized operations, mixing back-to-back and idle gaps.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rm = 1'($urandom);
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = {1'b0, {(W-1){1'b1}}};
                2: ra = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                check_idle_hold();
            end
            issue(ra, rb, rc, rm, model(ra, rb, rc, rm));
            wait_done(0);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
